mem_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer placing NUM_REQ processor read/write requests onto a single

---
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Round-robin arbiter and sequencer that puts NUM_REQ processor read/write
// requests onto one shared-memory port. One requester is selected, a single
// memory access is issued, the fixed memory latency is waited out, and then a
// one-cycle grant pulse goes back to that requester. For reads, the read data
// is returned alongside the grant.
//
// Configuration macros:
//   PROC_COUNT      default for NUM_REQ (4 if not defined elsewhere)
//   ARB_WR_PRIO_EN  when defined, pending writes win arbitration over reads;
//                   when undefined, one round-robin covers reads and writes
//
// Parameters:
//   NUM_REQ  number of requesters
//   ADDR_W   address width
//   DATA_W   data bus width
//   MEM_LAT  memory read latency in cycles (>= 1)
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_req_rd     per-requester read request (level, held until grant)
//   i_req_wr     per-requester write request (level, held until grant)
//   i_addr       flattened addresses, requester k at [k*ADDR_W +: ADDR_W]
//   i_wr_data    flattened write data, requester k at [k*DATA_W +: DATA_W]
//   i_wr_size    flattened 3-bit write size codes, passed through unchanged
//   o_grant_rd   one-hot pulse: read complete, o_rd_data valid
//   o_grant_wr   one-hot pulse: write committed
//   o_rd_data    last read data, held until the next read completes
//   o_mem_en     memory access strobe, one cycle per access
//   o_mem_we     1 = write, 0 = read (qualified by o_mem_en)
//   o_mem_addr   memory address
//   o_mem_wdata  memory write data
//   o_mem_wsize  memory write size
//   i_mem_rdata  memory read data, valid MEM_LAT cycles after o_mem_en
//   o_busy       high whenever the sequencer is not idle
// ---------------------------------------------------------------------------

`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

module mem_arbiter #(
  parameter int NUM_REQ = `PROC_COUNT,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 128,
  parameter int MEM_LAT = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_rd,
  input  logic [NUM_REQ-1:0]        i_req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_wr_data,
  input  logic [NUM_REQ*3-1:0]      i_wr_size,
  output logic [NUM_REQ-1:0]        o_grant_rd,
  output logic [NUM_REQ-1:0]        o_grant_wr,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic                      o_mem_en,
  output logic                      o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  output logic [2:0]                o_mem_wsize,
  input  logic [DATA_W-1:0]         i_mem_rdata,
  output logic                      o_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   lat_idx;
  logic               lat_we;
  logic [CNT_W-1:0]   wait_cnt;

  logic [NUM_REQ-1:0] arb_req;
  logic               hi_found;
  logic               lo_found;
  logic [IDX_W-1:0]   hi_idx;
  logic [IDX_W-1:0]   lo_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_we;
  logic [NUM_REQ-1:0] lat_onehot;
  logic [IDX_W-1:0]   ptr_next;

  // Candidate set for arbitration. With write priority, any pending write
  // hides all reads for this round; the shared pointer still rotates.
  always_comb begin
`ifdef ARB_WR_PRIO_EN
    arb_req = (|i_req_wr) ? i_req_wr : i_req_rd;
`else
    arb_req = i_req_rd | i_req_wr;
`endif
  end

  // Round-robin pick: the lowest requesting index at or above the pointer
  // wins. If none exists, the search wraps, and the lowest requesting index
  // overall wins. Scanning downward means the last hit found is the lowest.
  // A requester holding both rd and wr is serviced as a write first.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (arb_req[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    pick_valid = lo_found;
    pick_idx   = hi_found ? hi_idx : lo_idx;
    pick_we    = i_req_wr[pick_idx];
  end

  // Grant vector for the latched requester, and the pointer value that
  // follows it (wrapping NUM_REQ-1 back to 0).
  always_comb begin
    lat_onehot = NUM_REQ'(1) << lat_idx;
    ptr_next   = (lat_idx == IDX_W'(NUM_REQ - 1)) ? '0 : lat_idx + 1'b1;
  end

  // Sequencer: IDLE -> ISSUE -> (WAIT for reads) -> DONE -> IDLE.
  // All outputs are registered. Each output is set on the edge that enters
  // the state in which it must be visible. The request's address, data and
  // size are latched directly into the memory-port registers on the IDLE
  // edge, so later input changes cannot disturb the access in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      lat_idx     <= '0;
      lat_we      <= 1'b0;
      wait_cnt    <= '0;
      o_grant_rd  <= '0;
      o_grant_wr  <= '0;
      o_rd_data   <= '0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wsize <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_grant_rd <= '0;
      o_grant_wr <= '0;
      o_mem_en   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            lat_idx     <= pick_idx;
            lat_we      <= pick_we;
            o_mem_en    <= 1'b1;
            o_mem_we    <= pick_we;
            o_mem_addr  <= i_addr[pick_idx*ADDR_W +: ADDR_W];
            o_mem_wdata <= i_wr_data[pick_idx*DATA_W +: DATA_W];
            o_mem_wsize <= i_wr_size[pick_idx*3 +: 3];
            o_busy      <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (lat_we) begin
            o_grant_wr <= lat_onehot;
            state      <= ST_DONE;
          end else begin
            wait_cnt <= CNT_W'(MEM_LAT - 1);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The counter reaches zero in the cycle where memory presents the
          // data, i.e. MEM_LAT cycles after the strobe.
          if (wait_cnt == '0) begin
            o_rd_data  <= i_mem_rdata;
            o_grant_rd <= lat_onehot;
            state      <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          rr_ptr <= ptr_next;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed self-checking bench for mem_arbiter with its default parameters
// (4 requesters, 16-bit address, 128-bit data, read latency 2). Each task
// covers one scenario and compares the DUT outputs against hand-computed
// values. Expectations for the arbitration-priority scenario follow the
// ARB_WR_PRIO_EN macro.
// ---------------------------------------------------------------------------

module tb_mem_arbiter;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_rd;
  logic [NR-1:0]     req_wr;
  logic [NR*AW-1:0]  addr;
  logic [NR*DW-1:0]  wr_data;
  logic [NR*3-1:0]   wr_size;
  logic [NR-1:0]     grant_rd;
  logic [NR-1:0]     grant_wr;
  logic [DW-1:0]     rd_data;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [2:0]        mem_wsize;
  logic [DW-1:0]     mem_rdata;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [NR-1:0] log_grant [16];
  logic          log_wr    [16];
  int            log_n;
  logic          log_multi;
  logic          log_timeout;

  mem_arbiter dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_rd    (req_rd),
    .i_req_wr    (req_wr),
    .i_addr      (addr),
    .i_wr_data   (wr_data),
    .i_wr_size   (wr_size),
    .o_grant_rd  (grant_rd),
    .o_grant_wr  (grant_wr),
    .o_rd_data   (rd_data),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_wsize (mem_wsize),
    .i_mem_rdata (mem_rdata),
    .o_busy      (busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Acts as the requester pool: holds requests until granted, drops the
  // granted bit the cycle after its grant, and logs the grant order.
  task automatic collect(input int budget);
    logic [NR-1:0] drop_rd;
    logic [NR-1:0] drop_wr;
    int cyc;
    drop_rd     = '0;
    drop_wr     = '0;
    cyc         = 0;
    log_n       = 0;
    log_multi   = 1'b0;
    log_timeout = 1'b0;
    while (((req_rd | req_wr | drop_rd | drop_wr) != '0 || busy) && !log_timeout) begin
      step();
      req_rd  = req_rd & ~drop_rd;
      req_wr  = req_wr & ~drop_wr;
      drop_rd = '0;
      drop_wr = '0;
      if ((grant_rd | grant_wr) != '0) begin
        if ($countones({grant_rd, grant_wr}) != 1) log_multi = 1'b1;
        if (log_n < 16) begin
          log_grant[log_n] = grant_rd | grant_wr;
          log_wr[log_n]    = (grant_wr != '0);
        end
        log_n++;
        drop_rd = grant_rd;
        drop_wr = grant_wr;
      end
      cyc++;
      if (cyc > budget) log_timeout = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({grant_rd, grant_wr} !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_grants: got %b expected 0", {grant_rd, grant_wr});
    end
    n_checks++;
    if (rd_data !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_data);
    end
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, mem_wsize} !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_mem_port: got en=%b we=%b addr=%h wsize=%h expected all 0",
               mem_en, mem_we, mem_addr, mem_wsize);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL idle_after_reset: got busy=%b en=%b expected 0 0", busy, mem_en);
    end
  endtask

  // Read from requester 0 with MEM_LAT=2. The memory data is valid only in
  // cycle 3, so capturing in any other cycle shows up as wrong data.
  task automatic test_read();
    logic [DW-1:0] pat;
    pat = {16{8'hAB}};
    addr[0*AW +: AW] = 16'h0010;
    addr[1*AW +: AW] = 16'h0111;
    mem_rdata = {16{8'h11}};
    req_rd = 4'b0001;
    step();
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL read_strobe: got en=%b we=%b expected en=1 we=0", mem_en, mem_we);
    end
    n_checks++;
    if (mem_addr !== 16'h0010) begin
      n_errors++;
      $display("[TB] FAIL read_addr: got %h expected 0010", mem_addr);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL read_busy: got %b expected 1", busy);
    end
    step();
    n_checks++;
    if (mem_en !== 1'b0 || grant_rd !== 4'b0000) begin
      n_errors++;
      $display("[TB] FAIL read_cycle2: got en=%b grant_rd=%b expected 0 0000", mem_en, grant_rd);
    end
    step();
    mem_rdata = pat;
    n_checks++;
    if (grant_rd !== 4'b0000) begin
      n_errors++;
      $display("[TB] FAIL read_early_grant: got %b expected 0000", grant_rd);
    end
    step();
    mem_rdata = {16{8'h22}};
    n_checks++;
    if (grant_rd !== 4'b0001 || grant_wr !== 4'b0000) begin
      n_errors++;
      $display("[TB] FAIL read_grant: got rd=%b wr=%b expected rd=0001 wr=0000", grant_rd, grant_wr);
    end
    n_checks++;
    if (rd_data !== pat) begin
      n_errors++;
      $display("[TB] FAIL read_data: got %h expected %h", rd_data, pat);
    end
    step();
    req_rd = 4'b0000;
    n_checks++;
    if (grant_rd !== 4'b0000 || busy !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL read_after: got grant_rd=%b busy=%b expected 0000 0", grant_rd, busy);
    end
    n_checks++;
    if (rd_data !== pat) begin
      n_errors++;
      $display("[TB] FAIL read_data_hold: got %h expected %h", rd_data, pat);
    end
    step();
  endtask

  // Write from requester 2; neighbouring slots carry different values so a
  // wrong slot selection is visible.
  task automatic test_write();
    logic [DW-1:0] wpat;
    wpat = {16{8'h55}};
    addr[1*AW +: AW]    = 16'h0F01;
    addr[2*AW +: AW]    = 16'h0020;
    addr[3*AW +: AW]    = 16'h0F03;
    wr_data[1*DW +: DW] = {16{8'h01}};
    wr_data[2*DW +: DW] = wpat;
    wr_data[3*DW +: DW] = {16{8'h03}};
    wr_size[1*3 +: 3]   = 3'd6;
    wr_size[2*3 +: 3]   = 3'd3;
    wr_size[3*3 +: 3]   = 3'd5;
    req_wr = 4'b0100;
    step();
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL write_strobe: got en=%b we=%b expected en=1 we=1", mem_en, mem_we);
    end
    n_checks++;
    if (mem_addr !== 16'h0020 || mem_wsize !== 3'd3) begin
      n_errors++;
      $display("[TB] FAIL write_addr_size: got addr=%h size=%0d expected 0020 3", mem_addr, mem_wsize);
    end
    n_checks++;
    if (mem_wdata !== wpat) begin
      n_errors++;
      $display("[TB] FAIL write_data: got %h expected %h", mem_wdata, wpat);
    end
    step();
    n_checks++;
    if (grant_wr !== 4'b0100 || grant_rd !== 4'b0000) begin
      n_errors++;
      $display("[TB] FAIL write_grant: got wr=%b rd=%b expected wr=0100 rd=0000", grant_wr, grant_rd);
    end
    n_checks++;
    if (mem_en !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL write_en_pulse: got %b expected 0", mem_en);
    end
    step();
    req_wr = 4'b0000;
    n_checks++;
    if (grant_wr !== 4'b0000 || busy !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL write_after: got grant_wr=%b busy=%b expected 0000 0", grant_wr, busy);
    end
    step();
  endtask

  // Pointer is 3 after the grant to requester 2.
  task automatic test_wrap();
    req_rd = 4'b1001;
    collect(40);
    n_checks++;
    if (log_timeout || log_n != 2) begin
      n_errors++;
      $display("[TB] FAIL wrap_count: got %0d grants (timeout=%b) expected 2", log_n, log_timeout);
    end else begin
      n_checks++;
      if (log_grant[0] !== 4'b1000 || log_grant[1] !== 4'b0001) begin
        n_errors++;
        $display("[TB] FAIL wrap_order: got %b,%b expected 1000,0001", log_grant[0], log_grant[1]);
      end
    end
  endtask

  // Requester 1 asserts both ops: the write goes first, the read follows.
  task automatic test_both();
    req_rd = 4'b0010;
    req_wr = 4'b0010;
    collect(40);
    n_checks++;
    if (log_timeout || log_n != 2) begin
      n_errors++;
      $display("[TB] FAIL both_count: got %0d grants (timeout=%b) expected 2", log_n, log_timeout);
    end else begin
      n_checks++;
      if (log_grant[0] !== 4'b0010 || log_wr[0] !== 1'b1) begin
        n_errors++;
        $display("[TB] FAIL both_first: got grant=%b write=%b expected 0010 1", log_grant[0], log_wr[0]);
      end
      n_checks++;
      if (log_grant[1] !== 4'b0010 || log_wr[1] !== 1'b0) begin
        n_errors++;
        $display("[TB] FAIL both_second: got grant=%b write=%b expected 0010 0", log_grant[1], log_wr[1]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic stray;
    mem_rdata = {16{8'hCD}};
    req_rd = 4'b0001;
    step();
    n_checks++;
    if (mem_en !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL rstwait_issue: got en=%b expected 1", mem_en);
    end
    step();
    rst = 1'b1;
    req_rd = 4'b0000;
    step();
    rst = 1'b0;
    n_checks++;
    if ({grant_rd, grant_wr} !== '0 || busy !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL rstwait_state: got grants=%b busy=%b expected 0 0", {grant_rd, grant_wr}, busy);
    end
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, mem_wsize} !== '0 || rd_data !== '0) begin
      n_errors++;
      $display("[TB] FAIL rstwait_outputs: got en=%b addr=%h rd_data=%h expected all 0",
               mem_en, mem_addr, rd_data);
    end
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if ((grant_rd | grant_wr) != '0 || busy) stray = 1'b1;
    end
    n_checks++;
    if (stray !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL rstwait_stray: got activity=%b expected 0", stray);
    end
    req_rd = 4'b0011;
    collect(40);
    n_checks++;
    if (log_timeout || log_n != 2) begin
      n_errors++;
      $display("[TB] FAIL rstwait_count: got %0d grants (timeout=%b) expected 2", log_n, log_timeout);
    end else begin
      n_checks++;
      if (log_grant[0] !== 4'b0001 || log_grant[1] !== 4'b0010) begin
        n_errors++;
        $display("[TB] FAIL rstwait_order: got %b,%b expected 0001,0010", log_grant[0], log_grant[1]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [NR-1:0] exp_seq [4];
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_rd = 4'b1111;
    collect(80);
    n_checks++;
    if (log_timeout || log_n != 4) begin
      n_errors++;
      $display("[TB] FAIL fair_count: got %0d grants (timeout=%b) expected 4", log_n, log_timeout);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (log_grant[i] !== exp_seq[i] || log_wr[i] !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL fair_grant%0d: got %b write=%b expected %b 0", i, log_grant[i], log_wr[i], exp_seq[i]);
        end
      end
    end
    n_checks++;
    if (log_multi !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL fair_onehot: got multi-bit grant=%b expected 0", log_multi);
    end
    req_rd = 4'b0001;
    collect(40);
    n_checks++;
    if (log_timeout || log_n != 1 || log_grant[0] !== 4'b0001) begin
      n_errors++;
      $display("[TB] FAIL fair_again: got %0d grants first=%b expected 1 grant 0001", log_n, log_grant[0]);
    end
  endtask

  task automatic test_prio();
    logic [NR-1:0] exp_first;
    logic          exp_first_wr;
`ifdef ARB_WR_PRIO_EN
    exp_first    = 4'b0010;
    exp_first_wr = 1'b1;
`else
    exp_first    = 4'b0001;
    exp_first_wr = 1'b0;
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_rd = 4'b0001;
    req_wr = 4'b0010;
    collect(40);
    n_checks++;
    if (log_timeout || log_n != 2) begin
      n_errors++;
      $display("[TB] FAIL prio_count: got %0d grants (timeout=%b) expected 2", log_n, log_timeout);
    end else begin
      n_checks++;
      if (log_grant[0] !== exp_first || log_wr[0] !== exp_first_wr) begin
        n_errors++;
        $display("[TB] FAIL prio_first: got %b write=%b expected %b write=%b",
                 log_grant[0], log_wr[0], exp_first, exp_first_wr);
      end
      n_checks++;
      if (log_grant[1] !== (exp_first ^ 4'b0011) || log_wr[1] !== ~exp_first_wr) begin
        n_errors++;
        $display("[TB] FAIL prio_second: got %b write=%b expected %b write=%b",
                 log_grant[1], log_wr[1], exp_first ^ 4'b0011, ~exp_first_wr);
      end
    end
  endtask

  // Hard time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Runs every scenario in sequence and prints the summary.
  initial begin
    rst       = 1'b1;
    req_rd    = '0;
    req_wr    = '0;
    addr      = '0;
    wr_data   = '0;
    wr_size   = '0;
    mem_rdata = '0;
    test_reset();
    test_read();
    test_write();
    test_wrap();
    test_both();
    test_reset_mid_wait();
    test_fairness();
    test_prio();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
